// File: rtl/loa_pkg.sv
// Shared definitions for the sequential LOA adder: FSM encoding, mode
// constants and the chunk-counter width helper.
package loa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_EXACT = 1'b0;
    localparam logic MODE_LOA   = 1'b1;

    // A single-chunk adder still needs a one-bit counter to stay well formed.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/loa_chunk_adder.sv
// Combinational CHUNK-bit ripple segment; each bit is either a full adder or
// an LOA OR-bit, selected by the per-bit masks supplied by the caller.
module loa_chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic [CHUNK-1:0] approx_mask,
    input  logic [CHUNK-1:0] msb_mask,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (approx_mask[j]) begin
                // The top approximate bit feeds a&b into the exact part; lower ones kill the carry.
                sum[j] = a[j] | b[j];
                carry  = msb_mask[j] ? (a[j] & b[j]) : 1'b0;
            end else begin
                sum[j] = a[j] ^ b[j] ^ carry;
                carry  = (a[j] & b[j]) | (a[j] & carry) | (b[j] & carry);
            end
        end
        cout = carry;
    end

endmodule

// File: rtl/loa_seq_adder.sv
// Multi-cycle exact / lower-part-OR adder: one CHUNK-bit ripple segment per
// clock, carry held between segments, valid/ready on both sides.
module loa_seq_adder
    import loa_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CHUNK       = 8,
    parameter int APPROX_BITS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             mode_r, carry_r, cout_r;
    logic [CW-1:0]    cnt;
    logic             accept;

    logic [CHUNK-1:0] seg_a, seg_b, seg_sum, amask, mmask;
    logic             seg_cout;

    assign seg_a = a_r[cnt*CHUNK +: CHUNK];
    assign seg_b = b_r[cnt*CHUNK +: CHUNK];

    // Masks are per absolute bit index, so the approx/exact split may land mid-chunk.
    always_comb begin
        amask = '0;
        mmask = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (mode_r == MODE_LOA && (int'(cnt) * CHUNK + j) < APPROX_BITS)
                amask[j] = 1'b1;
            if (mode_r == MODE_LOA && (int'(cnt) * CHUNK + j) == APPROX_BITS - 1)
                mmask[j] = 1'b1;
        end
    end

    loa_chunk_adder #(
        .CHUNK(CHUNK)
    ) u_seg (
        .a          (seg_a),
        .b          (seg_b),
        .cin        (carry_r),
        .approx_mask(amask),
        .msb_mask   (mmask),
        .sum        (seg_sum),
        .cout       (seg_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            mode_r  <= MODE_EXACT;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            mode_r  <= approx_en;
            carry_r <= cin;
            cnt     <= '0;
        end else if (state == ST_RUN) begin
            sum_r[cnt*CHUNK +: CHUNK] <= seg_sum;
            carry_r                   <= seg_cout;
            cnt                       <= cnt + 1'b1;
            if (cnt == LAST) cout_r <= seg_cout;
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_loa_seq_adder.sv
// Directed bench for loa_seq_adder (WIDTH=32, CHUNK=8, APPROX_BITS=12).
module tb_loa_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    int  checks = 0;
    int  errors = 0;
    int  lat;
    time t_acc, t_prev;

    always #5 clk = ~clk;

    loa_seq_adder #(
        .WIDTH(32),
        .CHUNK(8),
        .APPROX_BITS(12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .approx_en(approx_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-level reference: {cout, sum} for APPROX_BITS=12.
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c0, input logic loa);
        logic        c;
        logic [31:0] s;
        c = c0;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            if (loa && i < 12) begin
                s[i] = x[i] | y[i];
                c    = (i == 11) ? (x[i] & y[i]) : 1'b0;
            end else begin
                s[i] = x[i] ^ y[i] ^ c;
                c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
            end
        end
        return {c, s};
    endfunction

    // Present operands in IDLE, wait for the accept edge, then scramble the inputs
    // (in_valid stays high) to show the operation in flight is unaffected.
    task automatic start_op(input logic [31:0] xa, input logic [31:0] xb,
                            input logic xc, input logic xm);
        @(negedge clk);
        chk("start_in_ready", in_ready, 1);
        a = xa; b = xb; cin = xc; approx_en = xm; in_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        chk("run_in_ready", in_ready, 0);
        a = ~xa; b = ~xb; cin = ~xc; approx_en = ~xm;
    endtask

    // Counts negedges after the accept edge until out_valid is sampled high.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                      input logic xc, input logic xm, input logic [32:0] exp);
        start_op(xa, xb, xc, xm);
        wait_valid(lat);
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_sum"}, sum, exp[31:0]);
        chk({tag, "_cout"}, cout, exp[32]);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 32'hDEADBEEF; b = 32'h1; cin = 1'b1; approx_en = 1'b0;
        t_acc = 0; t_prev = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Exact carry through all chunks
        op("exact_ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33'h1_00000000);

        // LOA ignores low carries and cin; exact counterpart
        op("loa_nocarry", 32'h00000FFF, 32'h00000001, 1'b1, 1'b1, 33'h0_00000FFF);
        op("exact_cin", 32'h00000FFF, 32'h00000001, 1'b1, 1'b0, 33'h0_00001001);

        // LOA MSB carry generation; exact counterpart
        op("loa_msbgen", 32'h00000800, 32'h00000800, 1'b0, 1'b1, 33'h0_00001800);
        op("exact_800", 32'h00000800, 32'h00000800, 1'b0, 1'b0, 33'h0_00001000);

        // Overflow wrap with mixed LOA split inside chunk 1
        op("loa_wrap", 32'hFFFFF000, 32'h00001000, 1'b1, 1'b1, 33'h1_00000000);

        // Backpressure: result held, new operands refused until consumed
        start_op(32'h00000005, 32'h00000007, 1'b0, 1'b0);
        wait_valid(lat);
        chk("bp_lat", lat, 5);
        a = 32'h0000FFFF; b = 32'h00010001; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum", sum, 32'h0000000C);
            chk("bp_cout", cout, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_idle", {out_valid, in_ready}, 2'b01);
        @(posedge clk);
        #1;
        chk("bp_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_next_lat", lat, 5);
        chk("bp_next_sum", sum, 32'h00020000);
        chk("bp_next_cout", cout, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset mid-RUN aborts the operation
        start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_result", {out_valid, in_ready}, 2'b01);
        op("after_reset", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 33'h0_23456789);

        // Streaming with out_ready high: one result every 6 cycles
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            logic        rc, rm;
            logic [32:0] exp;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rm = 1'(i % 2);
            exp = ref_add(ra, rb, rc, rm);
            t_prev = t_acc;
            start_op(ra, rb, rc, rm);
            if (i > 0) chk("stream_period", 64'((t_acc - t_prev) / 10), 6);
            wait_valid(lat);
            chk("stream_lat", lat, 5);
            chk("stream_sum", sum, exp[31:0]);
            chk("stream_cout", cout, exp[32]);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stream_end_idle", {out_valid, in_ready}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
